// File: rtl/axi_arbiter_2to1_pkg.sv
// axi_arbiter_2to1 shared types: FSM encoding, AXI resp codes, master index.
// Round-robin arbitration is enabled by defining AXI_ARB_RR_EN.
package axi_arbiter_2to1_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    WR   = 2'b10
  } arb_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int MIDX_W = 1;

endpackage

// File: rtl/axi_arbiter_2to1_pick.sv
// axi_arb_pick: combinational 2-way picker, one-hot grant.
// Fixed priority (m0 wins) unless AXI_ARB_RR_EN is defined.
module axi_arb_pick (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] grant
);

`ifdef AXI_ARB_RR_EN
  // ptr names the master preferred at this arbitration
  always_comb begin
    grant = 2'b00;
    if (ptr) begin
      grant[1] = req[1];
      grant[0] = req[0] & ~req[1];
    end else begin
      grant[0] = req[0];
      grant[1] = req[1] & ~req[0];
    end
  end
`else
  logic w_unused_ptr;
  assign w_unused_ptr = ptr;

  always_comb begin
    grant    = 2'b00;
    grant[0] = req[0];
    grant[1] = req[1] & ~req[0];
  end
`endif

endmodule

// File: rtl/axi_arbiter_2to1.sv
// Two-master AXI-lite arbiter, one whole transaction per grant.
// Define AXI_ARB_RR_EN for round-robin; default is m0-first fixed priority.
module axi_arbiter_2to1
  import axi_arbiter_2to1_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,

  input  logic [ADDR_W-1:0]   m0_araddr,
  input  logic                m0_arvalid,
  output logic                m0_arready,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic [1:0]          m0_rresp,
  output logic                m0_rvalid,
  input  logic                m0_rready,
  input  logic [ADDR_W-1:0]   m0_awaddr,
  input  logic                m0_awvalid,
  output logic                m0_awready,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  input  logic                m0_wvalid,
  output logic                m0_wready,
  output logic [1:0]          m0_bresp,
  output logic                m0_bvalid,
  input  logic                m0_bready,

  input  logic [ADDR_W-1:0]   m1_araddr,
  input  logic                m1_arvalid,
  output logic                m1_arready,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic [1:0]          m1_rresp,
  output logic                m1_rvalid,
  input  logic                m1_rready,
  input  logic [ADDR_W-1:0]   m1_awaddr,
  input  logic                m1_awvalid,
  output logic                m1_awready,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  input  logic                m1_wvalid,
  output logic                m1_wready,
  output logic [1:0]          m1_bresp,
  output logic                m1_bvalid,
  input  logic                m1_bready,

  output logic [ADDR_W-1:0]   s_araddr,
  output logic                s_arvalid,
  input  logic                s_arready,
  input  logic [DATA_W-1:0]   s_rdata,
  input  logic [1:0]          s_rresp,
  input  logic                s_rvalid,
  output logic                s_rready,
  output logic [ADDR_W-1:0]   s_awaddr,
  output logic                s_awvalid,
  input  logic                s_awready,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  output logic                s_wvalid,
  input  logic                s_wready,
  input  logic [1:0]          s_bresp,
  input  logic                s_bvalid,
  output logic                s_bready
);

  arb_state_e        r_state;
  arb_state_e        w_state_nxt;
  logic [MIDX_W-1:0] r_owner;
  logic [MIDX_W-1:0] w_owner_nxt;
  logic [1:0]        w_req;
  logic [1:0]        w_grant;
  logic              w_ptr;
  logic              w_rd_sel;

  assign w_req[0] = m0_arvalid | m0_awvalid | m0_wvalid;
  assign w_req[1] = m1_arvalid | m1_awvalid | m1_wvalid;

  axi_arb_pick u_pick (
    .req   (w_req),
    .ptr   (w_ptr),
    .grant (w_grant)
  );

`ifdef AXI_ARB_RR_EN
  logic r_ptr;

  // after granting m0, m1 is preferred next, and vice versa
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr <= 1'b0;
    end else if (r_state == IDLE && |w_grant) begin
      r_ptr <= w_grant[0];
    end
  end

  assign w_ptr = r_ptr;
`else
  assign w_ptr = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_owner <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_rd_sel    = 1'b0;
    case (r_state)
      IDLE: begin
        if (|w_grant) begin
          w_owner_nxt = w_grant[1];
          w_rd_sel    = w_grant[1] ? m1_arvalid : m0_arvalid;
          w_state_nxt = w_rd_sel ? RD : WR;
        end
      end
      RD: if (s_rvalid && s_rready) w_state_nxt = IDLE;
      WR: if (s_bvalid && s_bready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    s_araddr   = '0;
    s_arvalid  = 1'b0;
    s_rready   = 1'b0;
    s_awaddr   = '0;
    s_awvalid  = 1'b0;
    s_wdata    = '0;
    s_wstrb    = '0;
    s_wvalid   = 1'b0;
    s_bready   = 1'b0;
    m0_arready = 1'b0;
    m0_rdata   = '0;
    m0_rresp   = RESP_OKAY;
    m0_rvalid  = 1'b0;
    m0_awready = 1'b0;
    m0_wready  = 1'b0;
    m0_bresp   = RESP_OKAY;
    m0_bvalid  = 1'b0;
    m1_arready = 1'b0;
    m1_rdata   = '0;
    m1_rresp   = RESP_OKAY;
    m1_rvalid  = 1'b0;
    m1_awready = 1'b0;
    m1_wready  = 1'b0;
    m1_bresp   = RESP_OKAY;
    m1_bvalid  = 1'b0;
    case (r_state)
      RD: begin
        if (r_owner[0]) begin
          s_araddr   = m1_araddr;
          s_arvalid  = m1_arvalid;
          s_rready   = m1_rready;
          m1_arready = s_arready;
          m1_rdata   = s_rdata;
          m1_rresp   = s_rresp;
          m1_rvalid  = s_rvalid;
        end else begin
          s_araddr   = m0_araddr;
          s_arvalid  = m0_arvalid;
          s_rready   = m0_rready;
          m0_arready = s_arready;
          m0_rdata   = s_rdata;
          m0_rresp   = s_rresp;
          m0_rvalid  = s_rvalid;
        end
      end
      WR: begin
        if (r_owner[0]) begin
          s_awaddr   = m1_awaddr;
          s_awvalid  = m1_awvalid;
          s_wdata    = m1_wdata;
          s_wstrb    = m1_wstrb;
          s_wvalid   = m1_wvalid;
          s_bready   = m1_bready;
          m1_awready = s_awready;
          m1_wready  = s_wready;
          m1_bresp   = s_bresp;
          m1_bvalid  = s_bvalid;
        end else begin
          s_awaddr   = m0_awaddr;
          s_awvalid  = m0_awvalid;
          s_wdata    = m0_wdata;
          s_wstrb    = m0_wstrb;
          s_wvalid   = m0_wvalid;
          s_bready   = m0_bready;
          m0_awready = s_awready;
          m0_wready  = s_wready;
          m0_bresp   = s_bresp;
          m0_bvalid  = s_bvalid;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axi_arbiter_2to1.sv
// Directed bench for axi_arbiter_2to1 (default or AXI_ARB_RR_EN build).
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_axi_arbiter_2to1;

  logic        clk;
  logic        rst;
  logic [31:0] m0_araddr, m1_araddr, m0_awaddr, m1_awaddr;
  logic        m0_arvalid, m1_arvalid, m0_arready, m1_arready;
  logic [31:0] m0_rdata, m1_rdata;
  logic [1:0]  m0_rresp, m1_rresp;
  logic        m0_rvalid, m1_rvalid, m0_rready, m1_rready;
  logic        m0_awvalid, m1_awvalid, m0_awready, m1_awready;
  logic [31:0] m0_wdata, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        m0_wvalid, m1_wvalid, m0_wready, m1_wready;
  logic [1:0]  m0_bresp, m1_bresp;
  logic        m0_bvalid, m1_bvalid, m0_bready, m1_bready;
  logic [31:0] s_araddr, s_awaddr, s_rdata, s_wdata;
  logic        s_arvalid, s_arready, s_rvalid, s_rready;
  logic [1:0]  s_rresp, s_bresp;
  logic        s_awvalid, s_awready;
  logic [3:0]  s_wstrb;
  logic        s_wvalid, s_wready, s_bvalid, s_bready;

  int n_checks = 0;
  int n_errors = 0;
  int n_gnt;
  logic [31:0] gnt [4];
  logic [31:0] exp_gnt;

  axi_arbiter_2to1 #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid),
    .m0_arready(m0_arready), .m0_rdata(m0_rdata),
    .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid),
    .m0_rready(m0_rready), .m0_awaddr(m0_awaddr),
    .m0_awvalid(m0_awvalid), .m0_awready(m0_awready),
    .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_wvalid(m0_wvalid), .m0_wready(m0_wready),
    .m0_bresp(m0_bresp), .m0_bvalid(m0_bvalid),
    .m0_bready(m0_bready),
    .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid),
    .m1_arready(m1_arready), .m1_rdata(m1_rdata),
    .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid),
    .m1_rready(m1_rready), .m1_awaddr(m1_awaddr),
    .m1_awvalid(m1_awvalid), .m1_awready(m1_awready),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_wvalid(m1_wvalid), .m1_wready(m1_wready),
    .m1_bresp(m1_bresp), .m1_bvalid(m1_bvalid),
    .m1_bready(m1_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid),
    .s_arready(s_arready), .s_rdata(s_rdata),
    .s_rresp(s_rresp), .s_rvalid(s_rvalid),
    .s_rready(s_rready), .s_awaddr(s_awaddr),
    .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid),
    .s_bready(s_bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    {m0_araddr, m1_araddr, m0_awaddr, m1_awaddr} = '0;
    {m0_arvalid, m1_arvalid, m0_rready, m1_rready} = '0;
    {m0_awvalid, m1_awvalid, m0_wvalid, m1_wvalid} = '0;
    {m0_wdata, m1_wdata, m0_wstrb, m1_wstrb} = '0;
    {m0_bready, m1_bready} = '0;
    {s_arready, s_rdata, s_rresp, s_rvalid} = '0;
    {s_awready, s_wready, s_bresp, s_bvalid} = '0;

    // requests held during reset must not leak out
    m0_araddr  = 32'h0000_0100;
    m1_araddr  = 32'h8000_0000;
    m0_arvalid = 1'b1;
    m1_arvalid = 1'b1;
    s_arready  = 1'b1;
    repeat (3) begin
      @(negedge clk); #1;
      check("rst_m0_arready", m0_arready, 0);
      check("rst_m1_arready", m1_arready, 0);
      check("rst_s_arvalid", s_arvalid, 0);
    end
    check("rst_m0_rvalid", m0_rvalid, 0);
    check("rst_m0_rdata", m0_rdata, 0);

    @(negedge clk); rst = 1'b1; #1;
    check("rel_s_arvalid_0", s_arvalid, 0);
    @(negedge clk); #1;
    check("rel_s_arvalid_1", s_arvalid, 1);
    check("ct_m0_first_addr", s_araddr, 32'h0000_0100);
    check("ct_m0_arready", m0_arready, 1);
    check("ct_m1_wait", m1_arready, 0);

    @(negedge clk);
    m0_arvalid = 1'b0;
    s_rvalid = 1'b1; s_rdata = 32'h1111_2222;
    s_rresp = 2'b10; m0_rready = 1'b1; #1;
    check("m0_rvalid", m0_rvalid, 1);
    check("m0_rdata", m0_rdata, 32'h1111_2222);
    check("m0_rresp_slverr", m0_rresp, 2);
    check("m0_rd_m1_rvalid", m1_rvalid, 0);
    check("m0_rd_s_rready", s_rready, 1);

    @(negedge clk);
    s_rvalid = 1'b0; s_rdata = '0;
    s_rresp = 2'b00; m0_rready = 1'b0; #1;
    check("ct_idle_s_arvalid", s_arvalid, 0);
    check("ct_idle_m1_arready", m1_arready, 0);

    @(negedge clk); #1;
    check("ct_m1_s_arvalid", s_arvalid, 1);
    check("ct_m1_addr", s_araddr, 32'h8000_0000);
    check("ct_m1_arready", m1_arready, 1);
    check("ct_m1_m0_arready", m0_arready, 0);

    @(negedge clk);
    m1_arvalid = 1'b0;
    s_rvalid = 1'b1; s_rdata = 32'hDEAD_BEEF;
    m1_rready = 1'b1; #1;
    check("rd1_m1_rvalid", m1_rvalid, 1);
    check("rd1_m1_rdata", m1_rdata, 32'hDEAD_BEEF);
    check("rd1_m1_rresp", m1_rresp, 0);
    check("rd1_m0_rvalid", m0_rvalid, 0);
    check("rd1_m0_rdata", m0_rdata, 0);

    @(negedge clk);
    s_rvalid = 1'b0; s_rdata = '0; m1_rready = 1'b0; #1;
    check("rd1_done_m1_rvalid", m1_rvalid, 0);
    check("rd1_done_s_arvalid", s_arvalid, 0);

    // four back-to-back contended reads
    @(negedge clk);
    m0_arvalid = 1'b1; m1_arvalid = 1'b1;
    s_rvalid = 1'b1; m0_rready = 1'b1; m1_rready = 1'b1;
    n_gnt = 0;
    for (int c = 0; c < 20 && n_gnt < 4; c++) begin
      #1;
      if (m0_arready || m1_arready) begin
        gnt[n_gnt] = {31'b0, m1_arready};
        n_gnt++;
      end
      if (n_gnt < 4) @(negedge clk);
    end
    @(negedge clk);
    m0_arvalid = 1'b0; m1_arvalid = 1'b0;
    s_rvalid = 1'b0; m0_rready = 1'b0; m1_rready = 1'b0; #1;
    check("rr_grant_count", n_gnt, 4);
    for (int i = 0; i < n_gnt && i < 4; i++) begin
`ifdef AXI_ARB_RR_EN
      exp_gnt = i % 2;
`else
      exp_gnt = 0;
`endif
      check($sformatf("rr_grant_%0d", i), gnt[i], exp_gnt);
    end
    check("rr_idle_s_arvalid", s_arvalid, 0);

    // W leads AW by two cycles
    @(negedge clk);
    s_wready = 1'b1; s_awready = 1'b1;
    m0_wvalid = 1'b1; m0_wdata = 32'h1234_5678;
    m0_wstrb = 4'b0011; #1;
    check("sw_idle_s_wvalid", s_wvalid, 0);
    @(negedge clk); #1;
    check("sw_s_wvalid", s_wvalid, 1);
    check("sw_s_wdata", s_wdata, 32'h1234_5678);
    check("sw_s_wstrb", s_wstrb, 4'b0011);
    check("sw_m0_wready", m0_wready, 1);
    check("sw_s_awvalid_0", s_awvalid, 0);
    check("sw_m0_bvalid_0", m0_bvalid, 0);
    @(negedge clk);
    m0_wvalid = 1'b0; m0_awvalid = 1'b1;
    m0_awaddr = 32'h8000_0010; #1;
    check("sw_s_awvalid", s_awvalid, 1);
    check("sw_s_awaddr", s_awaddr, 32'h8000_0010);
    check("sw_m0_awready", m0_awready, 1);
    check("sw_s_wvalid_0", s_wvalid, 0);
    @(negedge clk);
    m0_awvalid = 1'b0;
    s_bvalid = 1'b1; s_bresp = 2'b00; m0_bready = 1'b1; #1;
    check("sw_m0_bvalid", m0_bvalid, 1);
    check("sw_m0_bresp", m0_bresp, 0);
    check("sw_m1_bvalid", m1_bvalid, 0);
    check("sw_s_bready", s_bready, 1);
    @(negedge clk); #1;
    check("sw_idle_m0_bvalid", m0_bvalid, 0);
    check("sw_idle_s_bready", s_bready, 0);
    check("sw_idle_m0_awready", m0_awready, 0);

    // one master with read and write together
    @(negedge clk);
    s_bvalid = 1'b0; m0_bready = 1'b0;
    m1_arvalid = 1'b1; m1_araddr = 32'h0000_0200;
    m1_awvalid = 1'b1; m1_awaddr = 32'h0000_0300;
    m1_wvalid = 1'b1; m1_wdata = 32'hCAFE_0001;
    m1_wstrb = 4'hF; #1;
    check("rw_idle_s_arvalid", s_arvalid, 0);
    @(negedge clk); #1;
    check("rw_rd_first", s_arvalid, 1);
    check("rw_rd_addr", s_araddr, 32'h0000_0200);
    check("rw_s_awvalid_0", s_awvalid, 0);
    check("rw_m1_awready_0", m1_awready, 0);
    @(negedge clk);
    m1_arvalid = 1'b0;
    s_rvalid = 1'b1; s_rdata = 32'hA5A5_A5A5;
    m1_rready = 1'b1; #1;
    check("rw_m1_rdata", m1_rdata, 32'hA5A5_A5A5);
    @(negedge clk);
    s_rvalid = 1'b0; s_rdata = '0; m1_rready = 1'b0; #1;
    check("rw_idle_s_awvalid", s_awvalid, 0);
    @(negedge clk); #1;
    check("rw_wr_s_awvalid", s_awvalid, 1);
    check("rw_wr_s_awaddr", s_awaddr, 32'h0000_0300);
    check("rw_wr_s_wdata", s_wdata, 32'hCAFE_0001);
    check("rw_wr_s_wstrb", s_wstrb, 4'hF);
    check("rw_m1_awready", m1_awready, 1);
    check("rw_m1_wready", m1_wready, 1);
    @(negedge clk);
    m1_awvalid = 1'b0; m1_wvalid = 1'b0;
    s_bvalid = 1'b1; m1_bready = 1'b1; #1;
    check("rw_m1_bvalid", m1_bvalid, 1);
    check("rw_m0_bvalid", m0_bvalid, 0);
    @(negedge clk);
    s_bvalid = 1'b0; m1_bready = 1'b0;

    // reset while a write waits for B
    m0_awvalid = 1'b1; m0_awaddr = 32'h0000_0500;
    m0_wvalid = 1'b1; m0_wdata = 32'h1; m0_wstrb = 4'hF; #1;
    check("mid_idle_m0_awready", m0_awready, 0);
    @(negedge clk); #1;
    check("mid_wr_m0_awready", m0_awready, 1);
    @(negedge clk);
    m0_awvalid = 1'b0; m0_wvalid = 1'b0; #1;
    check("mid_grant_held", m0_awready, 1);
    rst = 1'b0; #1;
    check("mid_rst_m0_awready", m0_awready, 0);
    check("mid_rst_m0_wready", m0_wready, 0);
    @(negedge clk);
    rst = 1'b1;
    m1_arvalid = 1'b1; m1_araddr = 32'h0000_0400; #1;
    check("mid_rel_s_arvalid_0", s_arvalid, 0);
    @(negedge clk); #1;
    check("mid_m1_s_arvalid", s_arvalid, 1);
    check("mid_m1_araddr", s_araddr, 32'h0000_0400);
    check("mid_m1_arready", m1_arready, 1);
    @(negedge clk);
    m1_arvalid = 1'b0;
    s_rvalid = 1'b1; s_rdata = 32'h55AA_55AA;
    m1_rready = 1'b1; #1;
    check("mid_m1_rvalid", m1_rvalid, 1);
    check("mid_m1_rdata", m1_rdata, 32'h55AA_55AA);
    @(negedge clk);
    s_rvalid = 1'b0; m1_rready = 1'b0; #1;
    check("mid_end_s_arvalid", s_arvalid, 0);
    check("mid_end_m1_rvalid", m1_rvalid, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/axi_arbiter_2to1.md
# axi_arbiter_2to1

Two-master to one-slave AXI-lite arbiter placed directly upstream of the memory-side AXI slave bridge. m0 is the LSU and m1 is the IFU. The block grants the single slave port to one master for one complete transaction, from address through response, so the slave never sees interleaved or concurrent masters. Only one transaction is outstanding on the slave port at any time.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; wstrb width is DATA_W/8

Ports (notation m{0,1}_x means one port per master):
- clk  input  1  sole clock
- rst  input  1  asynchronous, active-low reset
- m{0,1}_araddr, m{0,1}_arvalid  input  ADDR_W, 1  master read address and valid
- m{0,1}_arready  output  1  read address accepted
- m{0,1}_rdata, m{0,1}_rresp, m{0,1}_rvalid  output  DATA_W, 2, 1  read response
- m{0,1}_rready  input  1  master accepts read response
- m{0,1}_awaddr, m{0,1}_awvalid  input  ADDR_W, 1  write address
- m{0,1}_awready  output  1  write address accepted
- m{0,1}_wdata, m{0,1}_wstrb, m{0,1}_wvalid  input  DATA_W, DATA_W/8, 1  write data
- m{0,1}_wready  output  1  write data accepted
- m{0,1}_bresp, m{0,1}_bvalid  output  2, 1  write response
- m{0,1}_bready  input  1  master accepts write response
- s_araddr, s_arvalid, s_rready, s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready  output  as above  slave-side requests
- s_arready, s_rdata, s_rresp, s_rvalid, s_awready, s_wready, s_bresp, s_bvalid  input  as above  slave-side responses

## Operation
- State machine states: IDLE, RD, WR. The owner register (1 bit) records the granted master.
- Request per master i:
  - rd_req[i] = mi_arvalid
  - wr_req[i] = mi_awvalid | mi_wvalid
- Arbitration in IDLE:
  - Pick a master using the priority rule in Configuration.
  - Within the chosen master, a read wins over a write.
  - Next state is RD or WR; owner is loaded with the chosen master.
- RD state:
  - Owner's AR and R signals connect combinationally to s_ar* and s_r*.
  - Exit to IDLE on s_rvalid & mi_rready of the owner.
- WR state:
  - Owner's AW, W and B signals connect combinationally to s_aw*, s_w* and s_b*.
  - AW and W may complete in either order or in the same cycle.
  - Exit to IDLE on s_bvalid & mi_bready of the owner.
- Non-owner masters, and all masters while in IDLE, see:
  - all ready and valid outputs at 0
  - data and resp outputs at 0
- In IDLE, every s_*valid and s_*ready output is 0.
- Masters must hold valid until accepted. If a master drops valid after it is granted, the arbiter still keeps the grant until the response handshake completes.

## Timing
- Reset (rst = 0, asynchronous): state = IDLE, owner = 0, round-robin pointer = 0. Every valid and ready output is 0; every data and resp output is 0.
- Arbitration latency is 1 cycle. A request seen in IDLE at cycle N reaches the slave at cycle N+1. All slave-side paths are combinational passthrough with no added latency.
- Completion to IDLE takes 1 cycle. The response handshake at cycle M puts the arbiter in IDLE at M+1; the next grant is visible at M+2. A request present at M is held, not lost.
- Both masters requesting in the same cycle: exactly one is granted and the other waits, with its readies at 0.
- A master raising arvalid and awvalid in the same cycle: the read is served first, and the write is re-arbitrated after it.
- Reset asserted mid-transaction: the state returns to IDLE immediately. The slave is reset by the same rst, so no transaction is resumed.

## Configuration
- AXI_ARB_RR_EN
  - Defined: round-robin. The master granted last has the lowest priority at the next arbitration. The pointer updates only on a grant.
  - Undefined: fixed priority, with m0 (LSU) always winning. The pointer register is not built.

## Structure
- Shared package holds:
  - the state encoding: IDLE=2'b00, RD=2'b01, WR=2'b10
  - the AXI resp constants OKAY=2'b00 and SLVERR=2'b10
  - the master index width
- One sub-module, axi_arb_pick: a combinational 2-way picker with inputs req[1:0] and ptr, producing grant[1:0]. Its round-robin path is compiled under AXI_ARB_RR_EN.
- The FSM, owner and pointer registers, and the muxes stay in the top module.

## Test plan
- Reset: hold rst=0 while both masters drive arvalid=1 -> all m*_arready and s_arvalid stay 0; after release, s_arvalid rises exactly 1 cycle later.
- Single read: m1 reads 0x80000000, slave returns 0xDEADBEEF/OKAY -> m1_rdata=0xDEADBEEF, m1_rresp=0, m0 sees rvalid=0 throughout.
- Contention: m0 and m1 both read in the same cycle, without AXI_ARB_RR_EN -> m0 is served first and m1 second; the m1 grant appears 2 cycles after m0's R handshake.
- Round-robin: with AXI_ARB_RR_EN, both masters issue 4 back-to-back reads -> grants strictly alternate m0, m1, m0, m1.
- Split write: m0 sends W (0x12345678, strb 4'b0011) two cycles before AW 0x80000010 -> slave receives both; m0_bvalid is asserted once and IDLE follows the B handshake.
- Reset mid-op: assert rst while in WR before B -> state returns to IDLE; after release, a fresh m1 read completes normally.
